imem_boot_loader: RTL and testbench

// - Boot-time controller for the instruction memory write port: takes a byte stream (UART/debug

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 198 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Host byte link and IMEM write port seen by the boot loader.
// master = byte source / memory side, slave = loader.
interface imem_boot_loader_if #(
  parameter int AW = 8
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> sequential 32-bit IMEM writes, holds core in reset.
// Optional trailer checksum enabled by defining IMEM_LOAD_CKSUM_EN.
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_boot_loader_if.slave    bus,
  input  logic                 load_start,
  output logic                 core_rst_n,
  output logic                 load_done,
  output logic                 load_err,
  output logic [15:0]          word_cnt
);

`ifdef IMEM_LOAD_CKSUM_EN
  typedef enum logic [2:0] {
    S_HDR, S_DATA, S_CKS, S_RUN, S_ERR
  } state_t;
  localparam state_t S_FIN = S_CKS;
`else
  typedef enum logic [1:0] {
    S_HDR, S_DATA, S_RUN, S_ERR
  } state_t;
  localparam state_t S_FIN = S_RUN;
`endif

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t        state_q, state_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [23:0]   asm_q, asm_d;
  logic [7:0]    hdr_lo_q, hdr_lo_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          rx_ready_q, rx_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef IMEM_LOAD_CKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    sum_fin;
`endif

  logic          acc;
  logic [15:0]   hdr_n;
  logic [15:0]   wc_inc;

  assign acc    = bus.rx_valid & rx_ready_q;
  assign hdr_n  = {bus.rx_data, hdr_lo_q};
  assign wc_inc = word_cnt_q + 16'd1;
`ifdef IMEM_LOAD_CKSUM_EN
  assign sum_fin = sum_q + bus.rx_data;
`endif

  always_comb begin
    state_d    = state_q;
    bidx_d     = bidx_q;
    asm_d      = asm_q;
    hdr_lo_d   = hdr_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    mem_we_d   = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
`ifdef IMEM_LOAD_CKSUM_EN
    sum_d      = sum_q;
`endif
    unique case (state_q)
      S_HDR: begin
        if (acc) begin
`ifdef IMEM_LOAD_CKSUM_EN
          sum_d = sum_fin;
`endif
          if (bidx_q == 2'd0) begin
            hdr_lo_d = bus.rx_data;
            bidx_d   = 2'd1;
          end else begin
            n_d        = hdr_n;
            bidx_d     = 2'd0;
            word_cnt_d = 16'd0;
            if (hdr_n == 16'd0) begin
              state_d = S_FIN;
            end else if (hdr_n > DEPTH16) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (acc) begin
`ifdef IMEM_LOAD_CKSUM_EN
          sum_d = sum_fin;
`endif
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            // Byte 3 completes the little-endian word.
            mem_we_d   = 1'b1;
            waddr_d    = word_cnt_q[AW-1:0];
            wdata_d    = {bus.rx_data, asm_q};
            word_cnt_d = wc_inc;
            if (wc_inc == n_q) begin
              state_d = S_FIN;
            end
          end else begin
            asm_d = {bus.rx_data, asm_q[23:8]};
          end
        end
      end
`ifdef IMEM_LOAD_CKSUM_EN
      S_CKS: begin
        if (acc) begin
          sum_d   = sum_fin;
          state_d = (sum_fin == 8'h00) ? S_RUN : S_ERR;
        end
      end
`endif
      S_RUN, S_ERR: begin
        if (load_start) begin
          state_d    = S_HDR;
          word_cnt_d = 16'd0;
          bidx_d     = 2'd0;
`ifdef IMEM_LOAD_CKSUM_EN
          sum_d      = 8'h00;
`endif
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Status outputs are registered from the next state.
  always_comb begin
    rx_ready_d   = (state_d == S_HDR) || (state_d == S_DATA);
`ifdef IMEM_LOAD_CKSUM_EN
    if (state_d == S_CKS) begin
      rx_ready_d = 1'b1;
    end
`endif
    done_d       = (state_d == S_RUN);
    err_d        = (state_d == S_ERR);
    core_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      bidx_q       <= 2'd0;
      asm_q        <= 24'd0;
      hdr_lo_q     <= 8'd0;
      n_q          <= 16'd0;
      word_cnt_q   <= 16'd0;
      rx_ready_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 32'd0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
      sum_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      bidx_q       <= bidx_d;
      asm_q        <= asm_d;
      hdr_lo_q     <= hdr_lo_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      rx_ready_q   <= rx_ready_d;
      mem_we_q     <= mem_we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOAD_CKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign core_rst_n    = core_rst_n_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: byte-count model plus directed loads.
// Define IMEM_LOAD_CKSUM_EN to exercise the trailer build.
module tb_imem_boot_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_cnt;

  imem_boot_loader_if #(.AW(AW)) bus ();

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .load_start (load_start),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state derived from bytes accepted in the current load.
  int         m_cnt;
  int         m_n;
  bit         m_run, m_err;
  logic [7:0] m_sum;
  logic [7:0] m_hb0, m_hb1;
  logic [7:0] m_wb [4];
  int         m_wc;
  bit         m_we;
  logic [7:0] m_addr;
  logic [31:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_n = 0; m_run = 0; m_err = 0; m_sum = 8'h00;
      m_wc = 0; m_we = 0; m_addr = 8'h00; m_data = 32'h0;
    end else begin
      m_we = 0;
      if ((m_run || m_err) && load_start) begin
        m_cnt = 0; m_run = 0; m_err = 0; m_sum = 8'h00; m_wc = 0;
      end else if (!m_run && !m_err && bus.rx_valid) begin
        m_sum = m_sum + bus.rx_data;
        if (m_cnt == 0) m_hb0 = bus.rx_data;
        else if (m_cnt == 1) m_hb1 = bus.rx_data;
        else if (m_cnt < 2 + 4 * m_n) m_wb[(m_cnt - 2) % 4] = bus.rx_data;
        m_cnt++;
        if (m_cnt == 2) begin
          m_n = int'({m_hb1, m_hb0});
          if (m_n > DEPTH) m_err = 1;
        end
        if (!m_err && m_cnt > 2 && m_cnt <= 2 + 4 * m_n
            && (m_cnt - 2) % 4 == 0) begin
          m_we = 1;
          m_addr = 8'(m_wc);
          m_data = {m_wb[3], m_wb[2], m_wb[1], m_wb[0]};
          m_wc++;
        end
`ifdef IMEM_LOAD_CKSUM_EN
        if (!m_err && m_cnt == 3 + 4 * m_n) begin
          if (m_sum == 8'h00) m_run = 1;
          else m_err = 1;
        end
`else
        if (!m_err && m_cnt == 2 + 4 * m_n) m_run = 1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rx_ready", 32'(bus.rx_ready), 32'(!m_run && !m_err));
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_waddr", 32'(bus.mem_waddr), 32'(m_addr));
        chk("mem_wdata", bus.mem_wdata, m_data);
      end
      chk("core_rst_n", 32'(core_rst_n), 32'(m_run));
      chk("load_done", 32'(load_done), 32'(m_run));
      chk("load_err", 32'(load_err), 32'(m_err));
      chk("word_cnt", 32'(word_cnt), 32'(m_wc));
    end
  end

  // IMEM image and write counter, sampled mid-cycle.
  logic [31:0] imem [DEPTH];
  int          we_count = 0;
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      imem[bus.mem_waddr] = bus.mem_wdata;
      we_count++;
    end
  end

  logic [7:0] tsum;

  task automatic send(input logic [7:0] b, input int gap);
    int k;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tsum = tsum + b;
    k = 0;
    while (!bus.rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cks();
`ifdef IMEM_LOAD_CKSUM_EN
    send(8'h00 - tsum, 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    tsum = 8'h00;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int wc0;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tsum = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_waddr", 32'(bus.mem_waddr), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_done_err", {30'd0, load_done, load_err}, 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image, back to back.
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'h63, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
`ifndef IMEM_LOAD_CKSUM_EN
    chk("t1_last_we", 32'(bus.mem_we), 32'd1);
    chk("t1_release", {30'd0, core_rst_n, load_done}, 32'd3);
`endif
    send_cks();
    chk("t1_word_cnt", 32'(word_cnt), 32'd2);
    @(negedge clk); #1;
    chk("t1_rx_ready_after", 32'(bus.rx_ready), 32'd0);
    chk("t1_imem0", imem[0], 32'h00100013);
    chk("t1_imem1", imem[1], 32'h00000063);
    chk("t1_we_count", 32'(we_count), 32'd2);

    // Oversized header.
    pulse_start();
    send(8'h01, 0); send(8'h01, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t2_we_count", 32'(we_count), 32'd2);
    pulse_start();
    #1;
    chk("t2_restart_ready", 32'(bus.rx_ready), 32'd1);

    // Empty image.
    send(8'h00, 0); send(8'h00, 0);
    send_cks();
    #1;
    chk("t3_done", {30'd0, core_rst_n, load_done}, 32'd3);
    chk("t3_we_count", 32'(we_count), 32'd2);

    // One word with random gaps.
    pulse_start();
    send(8'h01, $urandom_range(0, 5)); send(8'h00, $urandom_range(0, 5));
    send(8'hDE, $urandom_range(0, 5)); send(8'hAD, $urandom_range(0, 5));
    send(8'hBE, $urandom_range(0, 5)); send(8'hEF, $urandom_range(0, 5));
    send_cks();
    @(negedge clk); #1;
    chk("t4_imem0", imem[0], 32'hEFBEADDE);
    chk("t4_we_count", 32'(we_count), 32'd3);

    // Reset in the middle of a second load.
    pulse_start();
    wc0 = we_count;
    send(8'h01, 0); send(8'h00, 0); send(8'h11, 0); send(8'h22, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("t5_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t5_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t5_word_cnt", 32'(word_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tsum = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_no_stray_we", 32'(we_count), 32'(wc0));
    chk("t5_imem0_kept", imem[0], 32'hEFBEADDE);
    send(8'h01, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send_cks();
    @(negedge clk); #1;
    chk("t5_fresh_word", imem[0], 32'h44332211);

`ifdef IMEM_LOAD_CKSUM_EN
    // 01+00+13+00+10+00 = 24h, so DCh closes the sum to zero.
    pulse_start();
    send(8'h01, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'hDC, 0);
    #1;
    chk("c1_run", {30'd0, load_done, load_err}, 32'd2);
    pulse_start();
    imem[0] = 32'h0;
    send(8'h01, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h00, 0); send(8'h10, 0); send(8'h00, 0);
    send(8'hDD, 0);
    #1;
    chk("c2_err", {30'd0, load_done, load_err}, 32'd1);
    chk("c2_word_written", imem[0], 32'h00100013);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
